// File: rtl/body_drive_ctrl_if.sv
// Avalon-MM slave bus bundle for the body drive controller register file.
interface body_drive_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/body_drive_ctrl.sv
// Motor drive controller: PWM generator with dead-time protected direction reversal,
// configured through a small Avalon-MM register file.
module body_drive_ctrl #(
    parameter int PWM_W = 16,
    parameter int DT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    body_drive_ctrl_if.slave   bus,
    output logic               dir_out,
    output logic               pwm_out,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DEAD   = 2'd2,
        SWITCH = 2'd3
    } state_t;

    localparam logic [PWM_W-1:0] PWM_ONE = PWM_W'(1);
    localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);

    logic             r_enable;
    logic             r_targetDir;
    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] r_period;
    logic [DT_W-1:0]  r_deadtime;

    state_t           r_state;
    logic [PWM_W-1:0] r_pwmCnt;
    logic [PWM_W-1:0] r_dutyShadow;
    logic [PWM_W-1:0] r_periodShadow;
    logic [DT_W-1:0]  r_deadCnt;
    logic             r_dir;
    logic             r_pwm;

    logic             w_write;
    state_t           w_nextState;
    logic [PWM_W-1:0] w_pwmCntNext;
    logic [DT_W-1:0]  w_deadCntNext;
    logic             w_loadShadow;
    logic             w_pwmNext;
    logic             w_dirNext;

    assign w_write = bus.chipselect && !bus.write_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable    <= 1'b0;
            r_targetDir <= 1'b0;
            r_duty      <= '0;
            r_period    <= '0;
            r_deadtime  <= '0;
        end else if (w_write) begin
            case (bus.address)
                3'd0: begin
                    r_enable    <= bus.writedata[0];
                    r_targetDir <= bus.writedata[1];
                end
                3'd1:    r_duty     <= PWM_W'(bus.writedata);
                3'd2:    r_period   <= PWM_W'(bus.writedata);
                3'd3:    r_deadtime <= DT_W'(bus.writedata);
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0:    bus.readdata = {30'd0, r_targetDir, r_enable};
            3'd1:    bus.readdata = 32'(r_duty);
            3'd2:    bus.readdata = 32'(r_period);
            3'd3:    bus.readdata = 32'(r_deadtime);
            3'd4:    bus.readdata = {27'd0, r_state, busy, r_pwm, r_dir};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_pwmCnt       <= '0;
            r_dutyShadow   <= '0;
            r_periodShadow <= '0;
            r_deadCnt      <= '0;
            r_dir          <= 1'b0;
            r_pwm          <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_pwmCnt  <= w_pwmCntNext;
            r_deadCnt <= w_deadCntNext;
            r_dir     <= w_dirNext;
            r_pwm     <= w_pwmNext;
            if (w_loadShadow) begin
                r_dutyShadow   <= r_duty;
                r_periodShadow <= r_period;
            end
        end
    end

    // pwm is only driven high while staying in RUN, so the edge that leaves RUN
    // drops it and the edge that re-enters RUN (where dir may flip) keeps it low.
    always_comb begin
        w_nextState   = r_state;
        w_pwmCntNext  = r_pwmCnt;
        w_deadCntNext = r_deadCnt;
        w_loadShadow  = 1'b0;
        w_pwmNext     = 1'b0;
        w_dirNext     = r_dir;
        case (r_state)
            IDLE: begin
                w_dirNext = r_targetDir;
                if (r_enable) begin
                    w_nextState  = RUN;
                    w_pwmCntNext = '0;
                    w_loadShadow = 1'b1;
                end
            end
            RUN: begin
                if (!r_enable) begin
                    w_nextState = IDLE;
                end else if (r_targetDir != r_dir) begin
                    w_nextState   = DEAD;
                    w_deadCntNext = r_deadtime;
                end else if (r_periodShadow == '0) begin
                    w_pwmCntNext = '0;
                    w_loadShadow = 1'b1;
                end else begin
                    w_pwmNext = (r_pwmCnt < r_dutyShadow);
                    if (r_pwmCnt >= r_periodShadow - PWM_ONE) begin
                        w_pwmCntNext = '0;
                        w_loadShadow = 1'b1;
                    end else begin
                        w_pwmCntNext = r_pwmCnt + PWM_ONE;
                    end
                end
            end
            DEAD: begin
                if (!r_enable) begin
                    w_nextState = IDLE;
                end else if (r_deadCnt == '0) begin
                    w_nextState = SWITCH;
                end else begin
                    w_deadCntNext = r_deadCnt - DT_ONE;
                end
            end
            SWITCH: begin
                if (!r_enable) begin
                    w_nextState = IDLE;
                end else begin
                    w_dirNext    = r_targetDir;
                    w_nextState  = RUN;
                    w_pwmCntNext = '0;
                    w_loadShadow = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign busy    = (r_state == DEAD) || (r_state == SWITCH);
    assign dir_out = r_dir;
    assign pwm_out = r_pwm;

endmodule

// File: tb/tb_body_drive_ctrl.sv
// Directed bench for body_drive_ctrl: register access, PWM shape, shadowing,
// dead-time reversal, abort to IDLE and reset during a reversal.
module tb_body_drive_ctrl;

    logic        clk;
    logic        reset;
    logic        dir_out;
    logic        pwm_out;
    logic        busy;
    logic [31:0] rd;
    int          compareCount;
    int          failCount;

    body_drive_ctrl_if bus ();

    body_drive_ctrl #(
        .PWM_W (16),
        .DT_W  (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .dir_out (dir_out),
        .pwm_out (pwm_out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One bus write issued at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    initial begin
        compareCount   = 0;
        failCount      = 0;
        reset          = 1'b1;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        checkBit("rst_dir", dir_out, 1'b0);
        checkBit("rst_pwm", pwm_out, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        readReg(3'd4, rd); checkOutput("rst_status", rd, 32'h0);
        readReg(3'd1, rd); checkOutput("rst_duty", rd, 32'h0);

        // register width masking, ignored addresses, chipselect gating
        applyStimulus(3'd3, 32'hFFFF_FFFF);
        readReg(3'd3, rd); checkOutput("deadtime_mask", rd, 32'h0000_FFFF);
        applyStimulus(3'd0, 32'hFFFF_FFFC);
        readReg(3'd0, rd); checkOutput("ctrl_mask", rd, 32'h0);
        applyStimulus(3'd4, 32'h0000_00FF);
        readReg(3'd4, rd); checkOutput("status_ro", rd, 32'h0);
        applyStimulus(3'd5, 32'h1234_5678);
        readReg(3'd5, rd); checkOutput("addr5_zero", rd, 32'h0);
        bus.address   = 3'd1;
        bus.writedata = 32'd7;
        bus.write_n   = 1'b0;
        @(negedge clk);
        bus.write_n   = 1'b1;
        readReg(3'd1, rd); checkOutput("no_cs_write", rd, 32'h0);

        // basic PWM: 3 high / 7 low, one cycle behind the counter
        applyStimulus(3'd2, 32'd10);
        applyStimulus(3'd1, 32'd3);
        applyStimulus(3'd0, 32'd1);
        @(negedge clk);
        readReg(3'd4, rd); checkOutput("run_status", rd, 32'h8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkBit($sformatf("run_pwm%0d", i), pwm_out, (i % 10) < 3);
        end

        // DUTY 3 -> 8 written while the counter is 5
        repeat (5) @(negedge clk);
        applyStimulus(3'd1, 32'd8);
        for (int j = 0; j < 20; j++) begin
            checkBit($sformatf("shadow_pwm%0d", j), pwm_out, (j >= 5) && (((j + 5) % 10) < 8));
            @(negedge clk);
        end

        // DUTY above PERIOD holds pwm high
        applyStimulus(3'd1, 32'd12);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checkBit($sformatf("full_pwm%0d", k), pwm_out, 1'b1);
            @(negedge clk);
        end

        // PERIOD 0 holds pwm low
        applyStimulus(3'd2, 32'd0);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checkBit($sformatf("zero_pwm%0d", k), pwm_out, 1'b0);
            @(negedge clk);
        end
        readReg(3'd4, rd); checkOutput("zero_status", rd, 32'h8);

        // reversal with DEADTIME=5: 6 DEAD + 1 SWITCH cycles
        applyStimulus(3'd0, 32'd0);
        applyStimulus(3'd1, 32'd3);
        applyStimulus(3'd2, 32'd10);
        applyStimulus(3'd3, 32'd5);
        readReg(3'd3, rd); checkOutput("deadtime_rb", rd, 32'd5);
        readReg(3'd4, rd); checkOutput("idle_status", rd, 32'h0);
        applyStimulus(3'd0, 32'd1);
        @(negedge clk);
        applyStimulus(3'd0, 32'd3);
        checkBit("rev_pre_pwm", pwm_out, 1'b1);
        checkBit("rev_pre_busy", busy, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkBit($sformatf("rev_busy%0d", i), busy, 1'b1);
            checkBit($sformatf("rev_pwm%0d", i), pwm_out, 1'b0);
            checkBit($sformatf("rev_dir%0d", i), dir_out, 1'b0);
            readReg(3'd4, rd);
            checkOutput($sformatf("rev_status%0d", i), rd, (i < 6) ? 32'h14 : 32'h1C);
        end
        @(negedge clk);
        checkBit("rev_end_busy", busy, 1'b0);
        checkBit("rev_end_dir", dir_out, 1'b1);
        checkBit("rev_end_pwm", pwm_out, 1'b0);
        readReg(3'd4, rd); checkOutput("rev_end_status", rd, 32'h9);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkBit($sformatf("resume_pwm%0d", k), pwm_out, k < 3);
        end

        // abort a reversal with CTRL=0, then dir tracks target in IDLE
        applyStimulus(3'd0, 32'd1);
        checkBit("abort_pre_busy", busy, 1'b0);
        @(negedge clk);
        checkBit("abort_dead_busy", busy, 1'b1);
        applyStimulus(3'd0, 32'd0);
        checkBit("abort_still_dead", busy, 1'b1);
        @(negedge clk);
        checkBit("abort_busy", busy, 1'b0);
        checkBit("abort_dir_held", dir_out, 1'b1);
        readReg(3'd4, rd); checkOutput("abort_status", rd, 32'h1);
        @(negedge clk);
        checkBit("idle_follow0", dir_out, 1'b0);
        applyStimulus(3'd0, 32'd2);
        checkBit("idle_lat", dir_out, 1'b0);
        @(negedge clk);
        checkBit("idle_follow1", dir_out, 1'b1);
        checkBit("idle_pwm", pwm_out, 1'b0);

        // reset during DEAD, together with a DUTY write
        applyStimulus(3'd0, 32'd3);
        applyStimulus(3'd0, 32'd1);
        @(negedge clk);
        checkBit("rst_dead_busy", busy, 1'b1);
        reset          = 1'b1;
        bus.address    = 3'd1;
        bus.writedata  = 32'h55;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        checkBit("rst2_dir", dir_out, 1'b0);
        checkBit("rst2_pwm", pwm_out, 1'b0);
        checkBit("rst2_busy", busy, 1'b0);
        readReg(3'd4, rd); checkOutput("rst2_status", rd, 32'h0);
        readReg(3'd0, rd); checkOutput("rst2_ctrl", rd, 32'h0);
        readReg(3'd1, rd); checkOutput("rst2_duty", rd, 32'h0);
        readReg(3'd2, rd); checkOutput("rst2_period", rd, 32'h0);
        readReg(3'd3, rd); checkOutput("rst2_deadtime", rd, 32'h0);
        repeat (3) @(negedge clk);
        readReg(3'd4, rd); checkOutput("rst2_stay_idle", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
